// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the bit serializer slice.
package bit_serializer_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/ser_hold_reg.sv
// One-entry valid/ready holding buffer feeding the serializer shift register.
module ser_hold_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             take,
  output logic [WIDTH-1:0] hold_data,
  output logic             hold_valid
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  assign in_ready   = !valid_q;
  assign hold_data  = data_q;
  assign hold_valid = valid_q;

  // Accept and take are mutually exclusive: accept needs the buffer empty, take needs it full.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (in_valid && in_ready) begin
      data_d  = in_data;
      valid_d = 1'b1;
    end else if (take) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word holding buffer and bit-rate strobe.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEFAULT,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bit_en,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy
);

  localparam int unsigned    CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_data;
  logic             hold_valid;
  logic             last_bit;
  logic             load;

  assign last_bit = (cnt_q == LAST);
  // Load from IDLE regardless of bit_en, or back-to-back when the last bit is consumed.
  assign load = hold_valid && ((state_q == IDLE) || (bit_en && last_bit));

  ser_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk       (clk),
    .rst_n     (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .take      (load),
    .hold_data (hold_data),
    .hold_valid(hold_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hold_valid) state_d = SHIFT;
      SHIFT:   if (bit_en && last_bit && !hold_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load) begin
      sr_d  = hold_data;
      cnt_d = '0;
    end else if ((state_q == SHIFT) && bit_en) begin
      if (last_bit) begin
        sr_d  = '0;
        cnt_d = '0;
      end else begin
        sr_d  = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    dout       = 1'b0;
    dout_valid = 1'b0;
    if (state_q == SHIFT) begin
      dout_valid = 1'b1;
      dout       = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
    end
    busy = hold_valid || (state_q == SHIFT);
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench: MSB-first and LSB-first instances against a queue-based word/bit model.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       bit_en;
  logic       in_ready_m, dout_m, dv_m, busy_m;
  logic       in_ready_l, dout_l, dv_l, busy_l;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_m),
    .bit_en(bit_en), .dout(dout_m), .dout_valid(dv_m), .busy(busy_m)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_l),
    .bit_en(bit_en), .dout(dout_l), .dout_valid(dv_l), .busy(busy_l)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: words waiting in the buffer, and the bits still to appear on dout.
  logic [7:0] hq[$];
  bit         bq_m[$];
  bit         bq_l[$];

  logic s_dout_m, s_dv_m, s_busy_m, s_ready_m, s_dout_l, s_dv_l;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       en;
    logic       dout;
    logic       dv;
    logic       busy;
    logic       rdy;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    hq.delete();
    bq_m.delete();
    bq_l.delete();
  endtask

  task automatic model_load();
    logic [7:0] w;
    w = hq.pop_front();
    for (int i = 0; i < 8; i++) begin
      bq_m.push_back(w[7-i]);
      bq_l.push_back(w[i]);
    end
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d, input logic en);
    bit ready_pre;
    ready_pre = (hq.size() == 0);
    if (bq_m.size() == 0) begin
      if (hq.size() != 0) model_load();
    end else if (en) begin
      void'(bq_m.pop_front());
      void'(bq_l.pop_front());
      if ((bq_m.size() == 0) && (hq.size() != 0)) model_load();
    end
    if (v && ready_pre) hq.push_back(d);
  endtask

  task automatic check_model();
    logic e_dv, e_dm, e_dl;
    e_dv = (bq_m.size() != 0);
    e_dm = e_dv ? bq_m[0] : 1'b0;
    e_dl = e_dv ? bq_l[0] : 1'b0;
    check("model_dv_m",    {31'd0, s_dv_m},     {31'd0, e_dv});
    check("model_dout_m",  {31'd0, s_dout_m},   {31'd0, e_dm});
    check("model_busy_m",  {31'd0, s_busy_m},   {31'd0, e_dv || (hq.size() != 0)});
    check("model_ready_m", {31'd0, s_ready_m},  {31'd0, hq.size() == 0});
    check("model_dv_l",    {31'd0, s_dv_l},     {31'd0, e_dv});
    check("model_dout_l",  {31'd0, s_dout_l},   {31'd0, e_dl});
  endtask

  // One clock cycle: drive inputs, sample and check at the falling edge, advance the model at the rising edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic en);
    in_valid = v;
    in_data  = d;
    bit_en   = en;
    @(negedge clk);
    s_dout_m  = dout_m;
    s_dv_m    = dv_m;
    s_busy_m  = busy_m;
    s_ready_m = in_ready_m;
    s_dout_l  = dout_l;
    s_dv_l    = dv_l;
    check_model();
    @(posedge clk);
    model_edge(v, d, en);
    #1;
  endtask

  task automatic check_idle_now(input string tag);
    check({tag, "_dout"},  {31'd0, dout_m},     32'd0);
    check({tag, "_dv"},    {31'd0, dv_m},       32'd0);
    check({tag, "_busy"},  {31'd0, busy_m},     32'd0);
    check({tag, "_ready"}, {31'd0, in_ready_m}, 32'd1);
    check({tag, "_dv_l"},  {31'd0, dv_l},       32'd0);
    check({tag, "_busy_l"},{31'd0, busy_l},     32'd0);
  endtask

  initial begin
    logic [7:0]  pat;
    logic [15:0] bits16;
    logic [7:0]  bits_m, bits_l;
    int          nv, first_i, last_i;

    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    bit_en   = 1'b0;
    model_clear();
    #3;
    check_idle_now("reset");
    @(posedge clk);
    #1 rst = 1'b1;

    // Single word A5, MSB first, bit_en constant.
    pat = 8'hA5;
    tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 2; i < 10; i++) tbl[i] = '{1'b0, 8'h00, 1'b1, pat[9-i], 1'b1, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].en);
      check($sformatf("tbl%0d_dout", i),  {31'd0, s_dout_m},  {31'd0, tbl[i].dout});
      check($sformatf("tbl%0d_dv", i),    {31'd0, s_dv_m},    {31'd0, tbl[i].dv});
      check($sformatf("tbl%0d_busy", i),  {31'd0, s_busy_m},  {31'd0, tbl[i].busy});
      check($sformatf("tbl%0d_ready", i), {31'd0, s_ready_m}, {31'd0, tbl[i].rdy});
    end

    // Back-to-back AA, 0F; a 33 offered while the buffer is full must be ignored.
    bits16 = '0; nv = 0; first_i = -1; last_i = -1;
    for (int i = 0; i < 22; i++) begin
      cycle(i < 3, (i == 0) ? 8'hAA : ((i == 1) ? 8'h33 : 8'h0F), 1'b1);
      if (s_dv_m) begin
        bits16 = {bits16[14:0], s_dout_m};
        nv++;
        if (first_i < 0) first_i = i;
        last_i = i;
      end
    end
    check("b2b_count", nv, 16);
    check("b2b_bits", {16'd0, bits16}, 32'h0000AA0F);
    check("b2b_nobubble", last_i - first_i, 15);

    // A0 with bit_en toggling: first shift cycle sees bit_en=0, each bit lasts two cycles.
    bits16 = '0; nv = 0;
    for (int i = 0; i < 22; i++) begin
      cycle(i == 0, 8'hA0, (i % 2) == 1);
      if (s_dv_m) begin
        bits16 = {bits16[14:0], s_dout_m};
        nv++;
      end
    end
    check("toggle_count", nv, 16);
    check("toggle_bits", {16'd0, bits16}, 32'h0000CC00);

    // Word 05 on both orders.
    bits_m = '0; bits_l = '0;
    for (int i = 0; i < 12; i++) begin
      cycle(i == 0, 8'h05, 1'b1);
      if (s_dv_m) bits_m = {bits_m[6:0], s_dout_m};
      if (s_dv_l) bits_l = {bits_l[6:0], s_dout_l};
    end
    check("order_msb", {24'd0, bits_m}, 32'h05);
    check("order_lsb", {24'd0, bits_l}, 32'hA0);

    // Reset after three bits of FF with 3C held.
    cycle(1'b1, 8'hFF, 1'b1);
    cycle(1'b1, 8'h3C, 1'b1);
    cycle(1'b1, 8'h3C, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    check("pre_reset_busy", {31'd0, busy_m}, 32'd1);
    check("pre_reset_held", {31'd0, in_ready_m}, 32'd0);
    #2 rst = 1'b0;
    #1;
    check_idle_now("async_reset");
    model_clear();
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      check("post_reset_idle", {31'd0, s_dv_m}, 32'd0);
    end
    for (int i = 0; i < 12; i++) cycle(i == 0, 8'h55, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 2) == 1, 8'($urandom), ($urandom % 5) < 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
